// File: rtl/uart_tx_fifo.sv
// Byte-wide 8N1 UART transmitter fed by a small power-of-two FIFO.
// Frames go out LSB first; a queued byte follows the previous stop bit with no idle gap.
module uart_tx_fifo #(
  parameter int ClkFreq   = 50_000_000,
  parameter int BaudRate  = 1_000_000,
  parameter int FifoDepth = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   data,
  input  logic                         valid,
  output logic                         ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FifoDepth):0]   level
);

  localparam int BitCycles = ClkFreq / BaudRate;
  localparam int PtrW      = $clog2(FifoDepth);
  localparam int CntW      = (BitCycles > 2) ? $clog2(BitCycles) : 1;

  localparam logic [CntW-1:0] LastCnt   = CntW'(BitCycles - 1);
  localparam logic [PtrW:0]   FullLevel = (PtrW + 1)'(FifoDepth);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  if (BitCycles < 2) begin : g_bad_baud
    $error("uart_tx_fifo: ClkFreq/BaudRate must give at least 2 cycles per bit");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FifoDepth must be a power of two and at least 2");
  end

  logic [7:0]      mem [FifoDepth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [1:0]      state;
  logic [CntW-1:0] baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            push;
  logic            pop;
  logic            boundary;

  assign ready    = (level != FullLevel);
  assign push     = valid && ready;
  assign boundary = (baud_cnt == LastCnt);
  // A pop happens either from idle or straight out of the last stop-bit cycle.
  assign pop      = (level != '0) && ((state == S_IDLE) || (state == S_STOP && boundary));
  assign busy     = (state != S_IDLE) || (level != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (PtrW + 1)'(1);
        2'b01:   level <= level - (PtrW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else if (state == S_IDLE) begin
      baud_cnt <= '0;
      tx       <= 1'b1;
      if (pop) begin
        shreg <= mem[rd_ptr];
        state <= S_START;
        tx    <= 1'b0;
      end
    end else if (!boundary) begin
      baud_cnt <= baud_cnt + CntW'(1);
    end else begin
      baud_cnt <= '0;
      case (state)
        S_START: begin
          tx      <= shreg[0];
          bit_idx <= '0;
          state   <= S_DATA;
        end
        S_DATA: begin
          if (bit_idx != 3'd7) begin
            shreg   <= {1'b0, shreg[7:1]};
            tx      <= shreg[1];
            bit_idx <= bit_idx + 3'd1;
          end else begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
        end
        default: begin
          if (pop) begin
            shreg <= mem[rd_ptr];
            state <= S_START;
            tx    <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and random stimulus for uart_tx_fifo, checked every cycle against a
// frame-timeline model: a byte queue plus a countdown of cycles left in the current frame.
module tb_uart_tx_fifo;

  localparam int BitCycles   = 50;
  localparam int FrameCycles = 10 * BitCycles;
  localparam int Depth       = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [2:0] level;

  uart_tx_fifo #(
    .ClkFreq   (50_000_000),
    .BaudRate  (1_000_000),
    .FifoDepth (Depth)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .tx    (tx),
    .busy  (busy),
    .level (level)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  int         rem = 0;
  logic [7:0] cur = 8'h00;
  bit         lastAcc = 1'b0;

  // Line value from the position inside the current 10-slot frame.
  function automatic logic expTx();
    int slot;
    if (rem == 0) return 1'b1;
    slot = (FrameCycles - rem) / BitCycles;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return cur[slot-1];
  endfunction

  task automatic modelEdge();
    int qsz;
    bit acc;
    if (!reset) begin
      q.delete();
      rem = 0;
      lastAcc = 1'b0;
      return;
    end
    qsz = q.size();
    acc = valid && (qsz < Depth);
    if (qsz > 0 && (rem == 0 || rem == 1)) begin
      cur = q.pop_front();
      rem = FrameCycles;
    end else if (rem > 0) begin
      rem--;
    end
    if (acc) q.push_back(data);
    lastAcc = acc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("tx", 32'(tx), 32'(expTx()));
    checkOutput("level", 32'(level), 32'(q.size()));
    checkOutput("busy", 32'(busy), 32'((rem > 0) || (q.size() > 0)));
    checkOutput("ready", 32'(ready), 32'(q.size() < Depth));
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    valid = v;
    data  = d;
  endtask

  task automatic pushByte(input logic [7:0] b);
    int waited = 0;
    applyStimulus(1'b1, b);
    do begin
      tick();
      waited++;
    end while (!lastAcc && waited < 3 * FrameCycles);
    checkOutput("push_accept", 32'(lastAcc), 32'd1);
    applyStimulus(1'b0, b);
  endtask

  initial begin
    logic [7:0] nextByte;

    $display("[TB] reset state");
    run(3);
    reset = 1'b1;
    run(2);

    $display("[TB] single byte 0x55");
    pushByte(8'h55);
    run(FrameCycles + 20);

    $display("[TB] back-to-back A3 00 FF");
    pushByte(8'hA3);
    pushByte(8'h00);
    pushByte(8'hFF);
    run(3 * FrameCycles + 20);

    $display("[TB] full FIFO with valid held");
    nextByte = 8'h10;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, nextByte);
      tick();
      if (lastAcc) nextByte++;
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("full_accepted", 32'(nextByte), 32'h15);
    run(5 * FrameCycles + 20);

    $display("[TB] reset mid-frame");
    pushByte(8'hC6);
    pushByte(8'h3B);
    pushByte(8'h81);
    run(250 - (FrameCycles - rem));
    #3 reset = 1'b0;
    modelEdge();
    #1 checkAll();
    run(3);
    reset = 1'b1;
    run(FrameCycles + 100);

    $display("[TB] wrap-around 01..09");
    for (int b = 1; b <= 9; b++) begin
      pushByte(8'(b));
      run($urandom_range(0, 700));
    end
    run(5 * FrameCycles);

    $display("[TB] idle with valid low");
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b0, 8'($urandom));
      tick();
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      if (!valid || lastAcc) applyStimulus(($urandom_range(0, 3) == 0), 8'($urandom));
      tick();
    end
    applyStimulus(1'b0, 8'h00);
    run(5 * FrameCycles + 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
